// File: rtl/regfile_pkg.sv
// Shared widths, the XZR index and the array types used by the
// 32 x 64-bit register file and its read multiplexers.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef logic [DATA_W-1:0] word_t;
  typedef word_t [NUM_REGS-1:0] regarray_t;

endpackage

// File: rtl/decoder5_32.sv
// Enabled 5:32 one-hot decoder built from one 2:4 stage selecting a bank
// of eight and four 3:8 stages decoding within the bank.
module dec2_4 (
  input  logic       en,
  input  logic [1:0] idx,
  output logic [3:0] onehot
);
  assign onehot = en ? (4'b0001 << idx) : 4'b0000;
endmodule

module dec3_8 (
  input  logic       en,
  input  logic [2:0] idx,
  output logic [7:0] onehot
);
  assign onehot = en ? (8'b0000_0001 << idx) : 8'b0000_0000;
endmodule

module decoder5_32
  import regfile_pkg::*;
(
  input  logic              en,
  input  logic [ADDR_W-1:0] idx,
  output logic [NUM_REGS-1:0] onehot
);
  logic [3:0] bank;

  dec2_4 u_hi (
    .en     (en),
    .idx    (idx[4:3]),
    .onehot (bank)
  );

  for (genvar b = 0; b < 4; b++) begin : g_bank
    dec3_8 u_lo (
      .en     (bank[b]),
      .idx    (idx[2:0]),
      .onehot (onehot[b*8 +: 8])
    );
  end
endmodule

// File: rtl/read_mux32.sv
// 32:1 x 64-bit read multiplexer shared by both register-file read ports.
module read_mux32
  import regfile_pkg::*;
(
  input  regarray_t         data,
  input  logic [ADDR_W-1:0] sel,
  output word_t             out
);
  assign out = data[sel];
endmodule

// File: rtl/reg_file_reg64.sv
// One 64-bit architectural register: hold-or-load mux per bit with a
// synchronous active-high clear.
module reg_file_reg64
  import regfile_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  word_t d,
  output word_t q
);
  // NOTE: the register file is small and must read zero after reset, so
  // every word gets a reset term; large RAM arrays are normally left unreset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so all registers sample the same edge.
    if (reset)     q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/reg_file.sv
// 32 x 64-bit integer register file: X0-X30 stored, X31 (XZR) reads as zero.
// Synchronous write through a one-hot decode, two combinational read ports.
module reg_file #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);
  logic [NUM_REGS-1:0]    wr_en;
  regfile_pkg::regarray_t regs;
  logic                   unused_xzr_en;

  decoder5_32 u_dec (
    .en     (RegWrite),
    .idx    (WriteRegister),
    .onehot (wr_en)
  );

  for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_reg
    reg_file_reg64 u_reg (
      .clk   (clk),
      .reset (reset),
      .load  (wr_en[i]),
      .d     (WriteData),
      .q     (regs[i])
    );
  end

  // XZR has no storage; its decoded enable goes nowhere, so writes to it vanish.
  assign regs[regfile_pkg::ZERO_REG] = '0;
  assign unused_xzr_en               = wr_en[regfile_pkg::ZERO_REG];

  read_mux32 u_rd1 (
    .data (regs),
    .sel  (ReadRegister1),
    .out  (ReadData1)
  );

  read_mux32 u_rd2 (
    .data (regs),
    .sel  (ReadRegister2),
    .out  (ReadData2)
  );
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed sequences, a vector table and
// randomized traffic against an array model of the architectural registers.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int errors = 0;
  int checks = 0;

  logic [63:0] model [32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [63:0] exp1;
    logic [63:0] exp2;
  } vec_t;

  vec_t vecs [7];

  reg_file dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [63:0] val);
    RegWrite      = 1'b1;
    WriteRegister = idx;
    WriteData     = val;
    step();
    RegWrite      = 1'b0;
  endtask

  task automatic model_edge(input logic rst, input logic we, input logic [4:0] wa,
                            input logic [63:0] wd);
    if (rst) begin
      for (int k = 0; k < 32; k++) model[k] = '0;
    end else if (we && wa != 5'd31) begin
      model[wa] = wd;
    end
  endtask

  task automatic sweep_model(input string tag);
    for (int k = 0; k < 32; k++) begin
      ReadRegister1 = 5'(k);
      ReadRegister2 = 5'(31 - k);
      #1;
      check($sformatf("%s_rd1_x%0d", tag, k), ReadData1, model[k]);
      check($sformatf("%s_rd2_x%0d", tag, 31 - k), ReadData2, model[31 - k]);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd7,  64'h7,                  5'd7,  5'd8,  64'h7,                  64'h0};
    vecs[1] = '{1'b1, 5'd8,  64'h8,                  5'd7,  5'd8,  64'h7,                  64'h8};
    vecs[2] = '{1'b0, 5'd7,  64'h99,                 5'd7,  5'd8,  64'h7,                  64'h8};
    vecs[3] = '{1'b1, 5'd31, 64'hDEAD_BEEF_DEAD_BEEF, 5'd31, 5'd7,  64'h0,                  64'h7};
    vecs[4] = '{1'b1, 5'd8,  64'h8,                  5'd8,  5'd8,  64'h8,                  64'h8};
    vecs[5] = '{1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 5'd0,  5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[6] = '{1'b1, 5'd30, 64'h1,                  5'd30, 5'd0,  64'h1,                  64'hFFFF_FFFF_FFFF_FFFF};

    // Reset cycle with a competing write to X3; XZR must read zero throughout.
    reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'hFFFF;
    ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
    #1;
    check("xzr_during_reset", ReadData1, 64'h0);
    step();
    reset = 1'b0; RegWrite = 1'b0;
    for (int k = 0; k < 32; k++) model[k] = '0;
    sweep_model("after_reset");

    // Vector table, starting from the all-zero state.
    for (int v = 0; v < 7; v++) begin
      RegWrite = vecs[v].we; WriteRegister = vecs[v].wa; WriteData = vecs[v].wd;
      ReadRegister1 = vecs[v].ra1; ReadRegister2 = vecs[v].ra2;
      step();
      check($sformatf("vec%0d_rd1", v), ReadData1, vecs[v].exp1);
      check($sformatf("vec%0d_rd2", v), ReadData2, vecs[v].exp2);
    end
    RegWrite = 1'b0;

    // Write every stored register with a distinct value, then sweep.
    for (int k = 0; k < 31; k++) write_reg(5'(k), 64'h0123_4567_89AB_0000 + 64'(k));
    ReadRegister2 = 5'd31;
    for (int k = 0; k < 31; k++) begin
      ReadRegister1 = 5'(k);
      #1;
      check($sformatf("sweep_x%0d", k), ReadData1, 64'h0123_4567_89AB_0000 + 64'(k));
      check($sformatf("sweep_xzr_p2_%0d", k), ReadData2, 64'h0);
    end

    // XZR write is a no-op for every register.
    write_reg(5'd31, 64'hDEAD_BEEF_DEAD_BEEF);
    ReadRegister1 = 5'd31; #1;
    check("xzr_after_write", ReadData1, 64'h0);
    for (int k = 0; k < 31; k++) begin
      ReadRegister1 = 5'(k); #1;
      check($sformatf("xzr_nochange_x%0d", k), ReadData1, 64'h0123_4567_89AB_0000 + 64'(k));
    end

    // Disabled write, then same-cycle read shows old value until the edge.
    write_reg(5'd5, 64'hAA);
    RegWrite = 1'b0; WriteRegister = 5'd5; WriteData = 64'h55; ReadRegister1 = 5'd5;
    step();
    check("we0_hold_x5", ReadData1, 64'hAA);
    RegWrite = 1'b1; #1;
    check("no_bypass_before_edge", ReadData1, 64'hAA);
    step();
    RegWrite = 1'b0;
    check("visible_after_edge", ReadData1, 64'h55);

    // Reset in the same cycle as a write to X10: the write is lost.
    write_reg(5'd10, 64'hCAFE);
    ReadRegister1 = 5'd10; #1;
    check("x10_cafe", ReadData1, 64'hCAFE);
    reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd10; WriteData = 64'h1234;
    step();
    reset = 1'b0; RegWrite = 1'b0;
    check("reset_beats_write_x10", ReadData1, 64'h0);
    for (int k = 0; k < 32; k++) model[k] = '0;
    sweep_model("mid_reset");

    // Randomized traffic against the array model, with occasional resets.
    for (int n = 0; n < 300; n++) begin
      logic        r_rst;
      logic        r_we;
      logic [4:0]  r_wa;
      logic [63:0] r_wd;
      r_rst = ($urandom_range(0, 19) == 0);
      r_we  = 1'($urandom_range(0, 1));
      r_wa  = 5'($urandom_range(0, 31));
      r_wd  = {32'($urandom), 32'($urandom)};
      reset = r_rst; RegWrite = r_we; WriteRegister = r_wa; WriteData = r_wd;
      ReadRegister1 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
      ReadRegister2 = 5'($urandom_range(0, 31));
      #1;
      check($sformatf("rand%0d_pre_rd1", n), ReadData1, model[ReadRegister1]);
      check($sformatf("rand%0d_pre_rd2", n), ReadData2, model[ReadRegister2]);
      step();
      model_edge(r_rst, r_we, r_wa, r_wd);
      check($sformatf("rand%0d_post_rd1", n), ReadData1, model[ReadRegister1]);
      check($sformatf("rand%0d_post_rd2", n), ReadData2, model[ReadRegister2]);
    end
    reset = 1'b0; RegWrite = 1'b0;
    sweep_model("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
